// File: rtl/bram0_loader.sv
// bram0_loader: packs a stream of IN_DATA_WIDTH-bit elements into DWIDTH-bit rows, lane 0 in
// the least significant bits, and writes the rows to consecutive BRAM0 addresses from 0.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start_load_i  start pulse, honoured only in IDLE
//   load_count_i  rows to write, latched at start and saturated to MEM_SIZE
//   s_valid_i     stream element valid
//   s_data_i      stream element
//   s_ready_o     element accepted this cycle when s_valid_i is high (RUN only)
//   idle_o        state is IDLE
//   run_o         state is RUN
//   done_o        state is DONE (one cycle, coincides with the final row write)
//   addr_b0_o     BRAM0 write address
//   ce_b0_o       BRAM0 chip enable, one pulse per row
//   we_b0_o       BRAM0 write enable, mirrors ce_b0_o
//   d_b0_o        packed row
module bram0_loader #(
  parameter int unsigned AWIDTH        = 8,
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_load_i,
  input  logic [AWIDTH:0]          load_count_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic                     idle_o,
  output logic                     run_o,
  output logic                     done_o,
  output logic [AWIDTH-1:0]        addr_b0_o,
  output logic                     ce_b0_o,
  output logic                     we_b0_o,
  output logic [DWIDTH-1:0]        d_b0_o
);

  localparam int unsigned LANES = DWIDTH / IN_DATA_WIDTH;
  localparam int unsigned LW    = $clog2(LANES);

  localparam logic [AWIDTH:0] MemRows  = (AWIDTH + 1)'(MEM_SIZE);
  localparam logic [AWIDTH:0] RowOne   = (AWIDTH + 1)'(1);
  localparam logic [LW-1:0]   LaneOne  = LW'(1);
  localparam logic [LW-1:0]   LastLane = LW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_next;

  logic [AWIDTH:0]   r_rows_total;
  logic [AWIDTH:0]   r_row;
  logic [LW-1:0]     r_lane;
  logic [DWIDTH-1:0] r_pack;
  logic              r_ce;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;

  logic [AWIDTH:0]   w_count_sat;
  logic              w_accept;
  logic              w_row_full;
  logic              w_last_row;
  logic [DWIDTH-1:0] w_row_data;

  assign w_count_sat = (load_count_i > MemRows) ? MemRows : load_count_i;
  // s_ready_o is decoded from state only, so accept never loops back through s_valid_i.
  assign w_accept    = s_valid_i && (r_state == StRun);
  assign w_row_full  = w_accept && (r_lane == LastLane);
  assign w_last_row  = (r_row + RowOne) == r_rows_total;

  // Current pack register with the incoming element merged into the active lane; on lane 3
  // this is the complete row that gets registered for the write.
  always_comb begin
    w_row_data = r_pack;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_lane == LW'(k)) begin
        w_row_data[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = s_data_i;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_load_i) begin
          w_state_next = (w_count_sat == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_row_full && w_last_row) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: counters, lane packing and the registered BRAM0 write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows_total <= '0;
      r_row        <= '0;
      r_lane       <= '0;
      r_pack       <= '0;
      r_ce         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_ce <= 1'b0;
      if ((r_state == StIdle) && start_load_i) begin
        r_rows_total <= w_count_sat;
        r_row        <= '0;
        r_lane       <= '0;
      end
      if (w_accept) begin
        r_pack <= w_row_data;
        r_lane <= r_lane + LaneOne;
        if (r_lane == LastLane) begin
          // Write fires next cycle; the next row's lanes can fill meanwhile.
          r_ce   <= 1'b1;
          r_addr <= r_row[AWIDTH-1:0];
          r_data <= w_row_data;
          r_row  <= r_row + RowOne;
        end
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    idle_o    = (r_state == StIdle);
    run_o     = (r_state == StRun);
    done_o    = (r_state == StDone);
    s_ready_o = (r_state == StRun);
    ce_b0_o   = r_ce;
    we_b0_o   = r_ce;
    addr_b0_o = r_addr;
    d_b0_o    = r_data;
  end

endmodule

// File: tb/tb_bram0_loader.sv
module tb_bram0_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int MS = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_load_i = 1'b0;
  logic [AW:0]   load_count_i = '0;
  logic          s_valid_i = 1'b0;
  logic [IW-1:0] s_data_i = '0;
  logic          s_ready_o, idle_o, run_o, done_o, ce_b0_o, we_b0_o;
  logic [AW-1:0] addr_b0_o;
  logic [DW-1:0] d_b0_o;

  bram0_loader #(
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .IN_DATA_WIDTH(IW),
    .MEM_SIZE     (MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_load_i(start_load_i),
    .load_count_i(load_count_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .idle_o      (idle_o),
    .run_o       (run_o),
    .done_o      (done_o),
    .addr_b0_o   (addr_b0_o),
    .ce_b0_o     (ce_b0_o),
    .we_b0_o     (we_b0_o),
    .d_b0_o      (d_b0_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed BRAM writes and done pulses.
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  int            obs_cyc[$];
  int            done_cyc[$];
  int            we_bad = 0;

  // Reference expectations.
  logic [DW-1:0] exp_row[$];
  int            exp_wcyc[$];

  int    t0;
  int    flag_bad;
  string flag_msg;
  string err_msg;

  always @(negedge clk) begin
    if (ce_b0_o === 1'b1) begin
      obs_addr.push_back(addr_b0_o);
      obs_data.push_back(d_b0_o);
      obs_cyc.push_back(cyc);
    end
    if (we_b0_o !== ce_b0_o) we_bad++;
    if (done_o === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); done_cyc.delete();
    exp_row.delete(); exp_wcyc.delete();
    we_bad = 0; flag_bad = 0; flag_msg = ""; err_msg = "";
  endtask

  // Drives one load and builds the expected write list from the element stream.
  // mode: 0 random data, 1 data=index, 2 data=index+1, 3 AA,BB,CC,DD...
  // bubble: <0 valid on odd cycles only, else percent chance of a bubble.
  task automatic run_load(input int count, input int mode, input int bubble, input bit spam,
                          input bit hold_valid);
    int rows, total, acc, done_k, k;
    bit finished, exp_run, vld;
    logic [7:0] elem[$];
    logic [3:0] expf, obsf;
    rows  = (count > MS) ? MS : count;
    total = rows * 4;
    for (int i = 0; i < total; i++) begin
      case (mode)
        0:       elem.push_back(8'($urandom));
        1:       elem.push_back(8'(i));
        2:       elem.push_back(8'(i + 1));
        default: elem.push_back(8'(8'hAA + 8'h11 * i));
      endcase
    end
    clear_obs();
    @(posedge clk); #1;
    t0 = cyc;
    start_load_i = 1'b1;
    load_count_i = (AW + 1)'(count);
    acc = 0;
    done_k = (rows == 0) ? 1 : -1;
    finished = 1'b0;
    for (k = 0; k < 4 * total + 40; k++) begin
      exp_run = (k >= 1) && (acc < total);
      if (k > 0) start_load_i = (spam && exp_run) ? 1'($urandom) : 1'b0;
      if (acc < total) begin
        vld = (bubble < 0) ? (k % 2 == 1) : (int'($urandom_range(99)) >= bubble);
        s_data_i = elem[acc];
      end else begin
        vld = hold_valid;
        s_data_i = 8'($urandom);
      end
      s_valid_i = vld;
      @(negedge clk);
      expf = {!exp_run && (k != done_k), exp_run, (k == done_k), exp_run};
      obsf = {idle_o, run_o, done_o, s_ready_o};
      if (obsf !== expf) begin
        flag_bad++;
        if (flag_bad == 1)
          flag_msg = $sformatf("cycle %0d idle/run/done/ready=%b want %b", k, obsf, expf);
      end
      if (vld && exp_run) begin
        acc++;
        if (acc % 4 == 0) begin
          exp_row.push_back({elem[acc-1], elem[acc-2], elem[acc-3], elem[acc-4]});
          exp_wcyc.push_back(t0 + k + 1);
        end
        if (acc == total) done_k = k + 1;
      end
      if (done_k >= 0 && k == done_k + 2) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!finished) begin
      flag_bad++;
      flag_msg = "load did not complete within cycle budget";
    end
    start_load_i = 1'b0;
    s_valid_i = 1'b0;
  endtask

  function automatic int write_errors();
    int e = 0;
    int n = (obs_data.size() < exp_row.size()) ? obs_data.size() : exp_row.size();
    if (obs_data.size() != exp_row.size()) begin
      e++;
      err_msg = $sformatf("write count %0d want %0d", obs_data.size(), exp_row.size());
    end
    for (int i = 0; i < n; i++) begin
      if (obs_addr[i] !== AW'(i) || obs_data[i] !== exp_row[i] || obs_cyc[i] !== exp_wcyc[i])
      begin
        if (e == 0)
          err_msg = $sformatf("row %0d addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                              i, obs_addr[i], obs_data[i], obs_cyc[i] - t0, AW'(i), exp_row[i],
                              exp_wcyc[i] - t0);
        e++;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({idle_o, run_o, done_o} !== 3'b100) begin
      failures++;
      $display("FAIL reset_state flags=%b want 100", {idle_o, run_o, done_o});
    end
    checks++;
    if (s_ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b want 0", s_ready_o);
    end
    checks++;
    if ({ce_b0_o, we_b0_o} !== 2'b00) begin
      failures++; $display("FAIL reset_ce_we got=%b want 00", {ce_b0_o, we_b0_o});
    end
    checks++;
    if (addr_b0_o !== '0 || d_b0_o !== '0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h want 0/0", addr_b0_o, d_b0_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (idle_o !== 1'b1 || ce_b0_o !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle idle=%b ce=%b want 1 0", idle_o, ce_b0_o);
    end
  endtask

  task automatic test_basic();
    run_load(2, 2, 0, 1'b0, 1'b0);
    checks++;
    if (write_errors() !== 0) begin
      failures++; $display("FAIL basic_writes %s", err_msg);
    end
    checks++;
    if (obs_data.size() != 2 || obs_data[0] !== 32'h04030201 || obs_cyc[0] - t0 != 5) begin
      failures++;
      $display("FAIL basic_row0 n=%0d data=%h cyc=%0d want 2 04030201 5", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : 'x,
               (obs_cyc.size() > 0) ? obs_cyc[0] - t0 : -1);
    end
    checks++;
    if (obs_data.size() != 2 || obs_data[1] !== 32'h08070605 || obs_cyc[1] - t0 != 9) begin
      failures++;
      $display("FAIL basic_row1 data=%h cyc=%0d want 08070605 9",
               (obs_data.size() > 1) ? obs_data[1] : 'x,
               (obs_cyc.size() > 1) ? obs_cyc[1] - t0 : -1);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 9) begin
      failures++;
      $display("FAIL basic_done pulses=%0d cyc=%0d want 1 at 9", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1);
    end
    checks++;
    if (flag_bad !== 0 || we_bad !== 0) begin
      failures++; $display("FAIL basic_flags %s we_bad=%0d want 0 errors", flag_msg, we_bad);
    end
  endtask

  task automatic test_bubbles();
    run_load(1, 3, -1, 1'b0, 1'b0);
    checks++;
    if (write_errors() !== 0) begin
      failures++; $display("FAIL bubbles_writes %s", err_msg);
    end
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL bubbles_row n=%0d data=%h want 1 DDCCBBAA", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : 'x);
    end
    checks++;
    if (flag_bad !== 0) begin
      failures++; $display("FAIL bubbles_flags %s", flag_msg);
    end
  endtask

  task automatic test_zero();
    run_load(0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (obs_data.size() != 0) begin
      failures++; $display("FAIL zero_writes got=%0d want 0", obs_data.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
      failures++;
      $display("FAIL zero_done pulses=%0d cyc=%0d want 1 at 1", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1);
    end
    checks++;
    if (flag_bad !== 0) begin
      failures++; $display("FAIL zero_flags %s", flag_msg);
    end
  endtask

  task automatic test_saturation();
    run_load(300, 1, 0, 1'b1, 1'b0);
    checks++;
    if (write_errors() !== 0) begin
      failures++; $display("FAIL sat_writes %s", err_msg);
    end
    checks++;
    if (obs_data.size() != 256 || obs_addr[255] !== 8'hFF || obs_data[255] !== 32'hFFFEFDFC)
    begin
      failures++;
      $display("FAIL sat_last n=%0d addr=%h data=%h want 256 FF FFFEFDFC", obs_data.size(),
               (obs_addr.size() > 0) ? obs_addr[obs_addr.size()-1] : 'x,
               (obs_data.size() > 0) ? obs_data[obs_data.size()-1] : 'x);
    end
    checks++;
    if (flag_bad !== 0 || we_bad !== 0) begin
      failures++; $display("FAIL sat_flags %s we_bad=%0d want 0 errors", flag_msg, we_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[6];
    for (int i = 0; i < 6; i++) e[i] = 8'(8'h10 + i);
    clear_obs();
    @(posedge clk); #1;
    t0 = cyc;
    start_load_i = 1'b1;
    load_count_i = 9'd3;
    s_valid_i = 1'b1;
    s_data_i = e[0];
    @(posedge clk); #1;
    start_load_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_data_i = e[k-1];
      @(posedge clk); #1;
    end
    s_valid_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({idle_o, run_o, done_o, s_ready_o, ce_b0_o, we_b0_o} !== 6'b100000) begin
      failures++;
      $display("FAIL rstmid_flags idle/run/done/ready/ce/we=%b want 100000",
               {idle_o, run_o, done_o, s_ready_o, ce_b0_o, we_b0_o});
    end
    checks++;
    if (addr_b0_o !== '0 || d_b0_o !== '0) begin
      failures++; $display("FAIL rstmid_port addr=%h data=%h want 0 0", addr_b0_o, d_b0_o);
    end
    checks++;
    if (obs_data.size() != 1 || obs_addr[0] !== 8'h00 || obs_data[0] !== {e[3], e[2], e[1], e[0]}
        || done_cyc.size() != 0) begin
      failures++;
      $display("FAIL rstmid_writes n=%0d data=%h done=%0d want 1 %h 0", obs_data.size(),
               (obs_data.size() > 0) ? obs_data[0] : 'x, done_cyc.size(),
               {e[3], e[2], e[1], e[0]});
    end
    run_load(1, 0, 0, 1'b0, 1'b0);
    checks++;
    if (write_errors() !== 0 || flag_bad !== 0) begin
      failures++; $display("FAIL rstmid_restart %s %s want no errors", err_msg, flag_msg);
    end
  endtask

  task automatic test_backpressure();
    run_load(2, 0, 20, 1'b0, 1'b1);
    checks++;
    if (write_errors() !== 0) begin
      failures++; $display("FAIL backpressure_writes %s", err_msg);
    end
    checks++;
    if (flag_bad !== 0) begin
      failures++; $display("FAIL backpressure_flags %s", flag_msg);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      run_load(int'($urandom_range(12, 1)), 0, 40, 1'b1, 1'($urandom));
      checks++;
      if (write_errors() !== 0 || flag_bad !== 0 || we_bad !== 0) begin
        failures++;
        $display("FAIL random_%0d %s %s we_bad=%0d want no errors", it, err_msg, flag_msg,
                 we_bad);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero();
    test_saturation();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
